// File: rtl/rob_pkg.sv
// Shared reorder-buffer constants and entry layout for the ROB, register status table and reservation stations.
// Latency: none, this file holds only declarations.
// Backpressure: none, this file holds only declarations.
package rob_pkg;
   localparam int ROB_DEPTH = 32;
   localparam int TAG_W     = 5;
   localparam int DATA_W    = 32;
   localparam int AREG_W    = 5;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic              has_dest;
      logic [AREG_W-1:0] rd_addr;
      logic [DATA_W-1:0] data;
   } rob_entry_t;
endpackage

// File: rtl/rob_ptr.sv
// Wrapping ring pointer with increment and synchronous clear.
// Latency: the new value appears one cycle after inc or clear.
// Backpressure: none; the owner decides when to increment.
module rob_ptr #(
   parameter int W = 5
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   // Clear wins over increment; the pointer wraps naturally at 2**W.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         ptr <= '0;
      else if (clear)
         ptr <= '0;
      else if (inc)
         ptr <= ptr + 1'b1;
   end

endmodule

// File: rtl/rob.sv
// Reorder buffer: allocates tags in order, captures CDB results and retires entries in program order.
// Latency: a CDB result becomes committable one cycle later; operand lookups forward the same cycle.
// Backpressure: disp_ready drops while all entries are in use; commit never stalls.
module rob #(
   parameter int DEPTH  = rob_pkg::ROB_DEPTH,
   parameter int TAG_W  = rob_pkg::TAG_W,
   parameter int DATA_W = rob_pkg::DATA_W,
   parameter int AREG_W = rob_pkg::AREG_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              disp_valid,
   input  logic              disp_has_dest,
   input  logic [AREG_W-1:0] disp_rd_addr,
   output logic              disp_ready,
   output logic [TAG_W-1:0]  disp_tag,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic [TAG_W-1:0]  rs_tag,
   output logic              rs_ready,
   output logic [DATA_W-1:0] rs_data,
   input  logic [TAG_W-1:0]  rt_tag,
   output logic              rt_ready,
   output logic [DATA_W-1:0] rt_data,
   output logic              commit_valid,
   output logic [TAG_W-1:0]  commit_tag,
   output logic              commit_has_dest,
   output logic [AREG_W-1:0] commit_rd_addr,
   output logic [DATA_W-1:0] commit_data,
   output logic [TAG_W:0]    count
);
   import rob_pkg::*;

   // Entry widths come from the package, so the width parameters must keep their package values.
   rob_entry_t       entries [DEPTH];
   rob_entry_t       head_e;
   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;
   logic             disp_fire;

   // Full check uses the current count only, so a same-cycle commit never frees a slot for dispatch.
   assign disp_ready = (count != (TAG_W+1)'(DEPTH));
   assign disp_fire  = disp_valid & disp_ready;
   assign disp_tag   = tail;

   assign head_e          = entries[head];
   assign commit_valid    = head_e.valid & head_e.done;
   assign commit_tag      = head;
   assign commit_has_dest = head_e.has_dest;
   assign commit_rd_addr  = head_e.rd_addr;
   assign commit_data     = head_e.data;

   rob_ptr #(.W(TAG_W)) u_head (
      .clock (clock),
      .reset (reset),
      .clear (flush),
      .inc   (commit_valid),
      .ptr   (head)
   );

   rob_ptr #(.W(TAG_W)) u_tail (
      .clock (clock),
      .reset (reset),
      .clear (flush),
      .inc   (disp_fire),
      .ptr   (tail)
   );

   // Entry array: flush discards everything, otherwise capture CDB, retire head and allocate tail.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            entries[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i].valid <= 1'b0;
            entries[i].done  <= 1'b0;
         end
      end else begin
         if (cdb_valid && entries[cdb_tag].valid) begin
            entries[cdb_tag].done <= 1'b1;
            entries[cdb_tag].data <= cdb_data;
         end
         if (commit_valid) begin
            entries[head].valid <= 1'b0;
            entries[head].done  <= 1'b0;
         end
         if (disp_fire) begin
            entries[tail].valid    <= 1'b1;
            entries[tail].done     <= 1'b0;
            entries[tail].has_dest <= disp_has_dest;
            entries[tail].rd_addr  <= disp_rd_addr;
         end
      end
   end

   // Occupancy: +1 per accepted dispatch, -1 per commit, unchanged when both happen.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else if (flush)
         count <= '0;
      else if (disp_fire && !commit_valid)
         count <= count + 1'b1;
      else if (!disp_fire && commit_valid)
         count <= count - 1'b1;
   end

   // Rs lookup: stored result, or the CDB result forwarded in the cycle it is broadcast.
   always_comb begin
      rs_ready = entries[rs_tag].valid & (entries[rs_tag].done | (cdb_valid & (cdb_tag == rs_tag)));
      rs_data  = (cdb_valid && (cdb_tag == rs_tag)) ? cdb_data : entries[rs_tag].data;
   end

   // Rt lookup: identical to Rs.
   always_comb begin
      rt_ready = entries[rt_tag].valid & (entries[rt_tag].done | (cdb_valid & (cdb_tag == rt_tag)));
      rt_data  = (cdb_valid && (cdb_tag == rt_tag)) ? cdb_data : entries[rt_tag].data;
   end

endmodule
